imm_encoder: RTL and testbench
==============================

# imm_encoder

Streaming RISC-V immediate encoder: the inverse of the core's immediate sign-extender. It takes a full 32-bit immediate, an ImmSrc format code and a base instruction word. It packs the immediate into the format's bit positions and checks that the value is representable. It then queues the word in a 2-entry output buffer and tags each word with a load address. It sits in the boot/test instruction-loader path, feeding words into instruction memory.

## Interface
- `BASE_ADDR`, default 32'h0000_0000: address tagged onto the first output word after reset or `clr`.
- `clk`  input  1  system clock; all state changes on rising edge.
- `rst_n`  input  1  synchronous, active-low reset.
- `clr`  input  1  synchronous clear of the address counter, error counter and sticky flag; buffer contents are kept.
- `in_valid`  input  1  request valid.
- `in_ready`  output  1  encoder can accept a request this cycle.
- `in_imm_src`  input  3  format: 000 I, 001 U, 010 S, 011 B, 100 J; others are invalid.
- `in_imm`  input  32  immediate value, two's complement.
- `in_base`  input  32  opcode/register/funct bits; immediate bit positions are ignored.
- `out_valid`  output  1  head word valid.
- `out_ready`  input  1  consumer accepts head word.
- `out_instr`  output  32  encoded instruction.
- `out_addr`  output  32  load address of the head word.
- `out_err`  output  1  head word's immediate was not representable, or its format was invalid.
- `err_sticky`  output  1  set by any accepted erroneous request.
- `err_count`  output  8  accepted erroneous requests, saturating at 255.

## Operation
- Packing (masked bits are taken from `imm`; every other bit is taken from `in_base`):
  - I: [31:20]=imm[11:0]; ok if imm[31:11] are all equal.
  - U: [31:12]=imm[19:0]. The field is unshifted, matching the decoder. Ok if imm[31:19] are all equal.
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]; ok if imm[31:11] are all equal.
  - B: [31]=imm[12], [7]=imm[11], [30:25]=imm[10:5], [11:8]=imm[4:1]; ok if imm[31:12] are all equal and imm[0]=0.
  - J: [31]=imm[20], [19:12]=imm[19:12], [20]=imm[11], [30:21]=imm[10:1]; ok if imm[31:20] are all equal and imm[0]=0.
  - Invalid code: word = `in_base` unchanged, and the error is set.
- Not-ok words are still emitted, with truncated bits, and `out_err`=1. The word is never dropped.
- Error accounting happens at accept time:
  - `err_sticky` is set.
  - `err_count` increments and saturates at 255.
- Address counter:
  - `out_addr` is the address of the current head word.
  - The counter advances by 4 on each output transfer (`out_valid && out_ready`).
  - It wraps modulo 2^32.
- Output buffer: a 2-entry FIFO of {instr, err}. Fill count is 0..2.

## Timing
- Reset (`rst_n`=0 at an edge):
  - buffer emptied, so `out_valid`=0;
  - `in_ready`=1;
  - address counter = BASE_ADDR;
  - `err_sticky`=0, `err_count`=0;
  - `out_instr`, `out_err` = 0.
- Reset mid-transfer discards buffered words; no partial state survives.
- `in_ready` = (count < 2). It is registered-state only and does not depend on `out_ready`.
  - Full buffer with a simultaneous pop: no push that cycle.
- Latency:
  - A request accepted at edge N appears at the head at N+1 if the buffer was empty.
  - Otherwise it appears after the words ahead of it drain.
- Throughput: 1 word/cycle with `out_ready` held high.
- Simultaneous push and pop at count 1: count stays 1, and the head advances to the new word.
- `out_valid` asserted with `out_ready`=0:
  - `out_instr`, `out_addr` and `out_err` hold stable until transfer.
- `clr` priority:
  - Reset overrides `clr`.
  - `clr` overrides a same-cycle increment. The counter loads BASE_ADDR; `err_count` becomes 0 and `err_sticky` becomes 0, even if an erroneous request is accepted the same cycle.
- Outputs are driven from registers/FIFO storage; there is no combinational path from `in_*` to `out_*`.

## Structure
- Shared package:
  - ImmSrc constants IMM_I, IMM_U, IMM_S, IMM_B, IMM_J. These are shared with the decoder so that both ends use one encoding.
  - A typedef for the {instr, err} buffer entry.
- Sub-module `imm_pack`: purely combinational packing and range check (imm, imm_src, base -> instr, err).
- The top level holds the FIFO, address counter and error counters.

## Test plan
- I round trip: imm=32'hFFFF_F800, base=32'h0000_0013 -> out_instr=32'h8000_0013, out_err=0, out_addr=BASE_ADDR. Feeding [31:7] to the decoder with ImmSrc=000 returns 32'hFFFF_F800.
- B range/alignment:
  - imm=32'h0000_1000 -> out_err=1, err_count=1.
  - imm=32'h0000_0FFE -> out_err=0, [31]=0, [7]=1, [30:25]=6'h3F, [11:8]=4'hF.
  - imm=3 -> out_err=1.
- Backpressure: out_ready=0 with 3 back-to-back requests -> in_ready low after 2 accepts. Release -> words emerge in order at addresses BASE, +4, +8; outputs are stable while stalled.
- Full-rate stream: 16 J requests with out_ready=1 -> 16 words on consecutive cycles, out_addr stepping by 4, and a decoder round trip matching every imm.
- Invalid code 3'b111 -> out_instr=in_base, out_err=1, err_sticky=1. 300 errors -> err_count=255.
- Reset and clr:
  - rst_n=0 with 2 words queued -> out_valid=0 next cycle, address=BASE_ADDR.
  - clr together with an erroneous accept -> err_count=0, err_sticky=0.

Source files
------------

// File: rtl/imm_encoder_pkg.sv
// Shared definitions for the RISC-V immediate encoder and its decoder peer.
package imm_encoder_pkg;

    // ImmSrc format codes, identical to the decoder's sign-extender select.
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_U = 3'b001;
    localparam logic [2:0] IMM_S = 3'b010;
    localparam logic [2:0] IMM_B = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam int unsigned FIFO_DEPTH = 2;

    // One output buffer slot: encoded word plus its representability flag.
    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } fifo_entry_t;

    // True when bits [31:sign_bit] of v are all equal, i.e. v fits a signed
    // field whose top bit is sign_bit.
    function automatic logic sign_fits(input logic [31:0] v, input int unsigned sign_bit);
        logic [31:0] s;
        s = $unsigned($signed(v) >>> sign_bit);
        return (s == '0) || (s == '1);
    endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response bus of the immediate encoder, plus its error status.
interface imm_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_imm_src;
    logic [31:0] in_imm;
    logic [31:0] in_base;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        out_err;
    logic        err_sticky;
    logic [7:0]  err_count;

    // Encoder side.
    modport slave (
        input  in_valid, in_imm_src, in_imm, in_base, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_err,
               err_sticky, err_count
    );

    // Request producer / word consumer side.
    modport master (
        output in_valid, in_imm_src, in_imm, in_base, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_err,
               err_sticky, err_count
    );
endinterface

// File: rtl/imm_encoder_pack.sv
// Combinational packing of a 32-bit immediate into an instruction word,
// with a representability check for the selected format.
module imm_pack
    import imm_encoder_pkg::*;
(
    input  logic [31:0] imm_i,
    input  logic [2:0]  imm_src_i,
    input  logic [31:0] base_i,
    output logic [31:0] instr_o,
    output logic        err_o
);

    // Scatter immediate bits into the format's fields; keep base elsewhere.
    always_comb begin
        instr_o = base_i;
        err_o   = 1'b1;
        case (imm_src_i)
            IMM_I: begin
                instr_o = {imm_i[11:0], base_i[19:0]};
                err_o   = !sign_fits(imm_i, 11);
            end
            IMM_U: begin
                // Unshifted 20-bit field, matching how the decoder extends it.
                instr_o = {imm_i[19:0], base_i[11:0]};
                err_o   = !sign_fits(imm_i, 19);
            end
            IMM_S: begin
                instr_o = {imm_i[11:5], base_i[24:12], imm_i[4:0], base_i[6:0]};
                err_o   = !sign_fits(imm_i, 11);
            end
            IMM_B: begin
                instr_o = {imm_i[12], imm_i[10:5], base_i[24:12],
                           imm_i[4:1], imm_i[11], base_i[6:0]};
                err_o   = !sign_fits(imm_i, 12) || imm_i[0];
            end
            IMM_J: begin
                instr_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12],
                           base_i[11:0]};
                err_o   = !sign_fits(imm_i, 20) || imm_i[0];
            end
            default: begin
                instr_o = base_i;
                err_o   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Streaming immediate encoder: packs requests, queues them in a 2-entry
// buffer and tags each head word with its instruction-memory load address.
module imm_encoder
    import imm_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    imm_encoder_if.slave bus
);

    fifo_entry_t mem_q [FIFO_DEPTH];
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [1:0]  count_q,  count_d;
    logic [31:0] addr_q,   addr_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic        sticky_q, sticky_d;

    logic [31:0] pack_instr;
    logic        pack_err;
    logic        push;
    logic        pop;
    fifo_entry_t head;

    imm_pack u_pack (
        .imm_i     (bus.in_imm),
        .imm_src_i (bus.in_imm_src),
        .base_i    (bus.in_base),
        .instr_o   (pack_instr),
        .err_o     (pack_err)
    );

    // Handshakes and head-of-buffer outputs; all outputs derive from state.
    always_comb begin
        bus.in_ready  = (count_q < 2'd2);
        bus.out_valid = (count_q != 2'd0);
        push          = bus.in_valid && bus.in_ready;
        pop           = bus.out_valid && bus.out_ready;
        head          = mem_q[rd_ptr_q];
        // An empty buffer presents zeros rather than a stale slot.
        bus.out_instr = bus.out_valid ? head.instr : 32'h0;
        bus.out_err   = bus.out_valid ? head.err : 1'b0;
        bus.out_addr  = addr_q;
        bus.err_sticky = sticky_q;
        bus.err_count  = err_cnt_q;
    end

    // Next-state for buffer pointers, address counter and error accounting.
    always_comb begin
        rd_ptr_d  = rd_ptr_q ^ pop;
        wr_ptr_d  = wr_ptr_q ^ push;
        count_d   = count_q;
        addr_d    = addr_q;
        err_cnt_d = err_cnt_q;
        sticky_d  = sticky_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
        if (pop) begin
            addr_d = addr_q + 32'd4;
        end
        if (push && pack_err) begin
            sticky_d = 1'b1;
            if (err_cnt_q != 8'hFF) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
        // Clear wins over any same-cycle advance or error increment.
        if (clr) begin
            addr_d    = BASE_ADDR;
            err_cnt_d = 8'h00;
            sticky_d  = 1'b0;
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q  <= 1'b0;
            wr_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            addr_q    <= BASE_ADDR;
            err_cnt_q <= 8'h00;
            sticky_q  <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            addr_q    <= addr_d;
            err_cnt_q <= err_cnt_d;
            sticky_q  <= sticky_d;
        end
    end

    // Buffer storage: written on accept, outputs gated by the fill count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= '{instr: pack_instr, err: pack_err};
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder with a reference immediate decoder.
module tb_imm_encoder;
    import imm_encoder_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic clk;
    logic rst_n;
    logic clr;
    int   checks;
    int   failures;

    imm_encoder_if bus ();

    imm_encoder #(.BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decoder: sign-extend the immediate out of an instruction.
    function automatic logic [31:0] decode(input logic [2:0] src, input logic [31:0] i);
        case (src)
            IMM_I:   return {{20{i[31]}}, i[31:20]};
            IMM_U:   return {{12{i[31]}}, i[31:12]};
            IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] src, input logic [31:0] imm, input logic [31:0] base);
        bus.in_valid   = 1'b1;
        bus.in_imm_src = src;
        bus.in_imm     = imm;
        bus.in_base    = base;
        step();
        bus.in_valid   = 1'b0;
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    logic [31:0] jimm [16];

    initial begin
        checks = 0;
        failures = 0;
        jimm = '{32'h000F_FFFE, 32'hFFF0_0000, 32'h0000_0000, 32'h0000_0002,
                 32'hFFFF_FFFE, 32'h0001_2344, 32'hFFFE_DCBA, 32'h0008_0000,
                 32'h0007_FFFE, 32'h0000_0800, 32'hFFFF_F800, 32'h0000_1000,
                 32'h0005_5554, 32'hFFFA_AAAA, 32'h0000_07FE, 32'hFFF8_0002};

        rst_n = 1'b0;
        clr   = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_imm_src = 3'b000;
        bus.in_imm     = 32'h0;
        bus.in_base    = 32'h0;
        bus.out_ready  = 1'b0;
        step();
        step();
        rst_n = 1'b1;

        // Reset state
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_addr", bus.out_addr, BASE);
        chk("rst_sticky", bus.err_sticky, 1'b0);
        chk("rst_err_count", bus.err_count, 8'd0);
        chk("rst_out_instr", bus.out_instr, 32'h0);
        chk("rst_out_err", bus.out_err, 1'b0);

        // I-format round trip
        push(IMM_I, 32'hFFFF_F800, 32'h0000_0013);
        chk("i_valid", bus.out_valid, 1'b1);
        chk("i_instr", bus.out_instr, 32'h8000_0013);
        chk("i_err", bus.out_err, 1'b0);
        chk("i_addr", bus.out_addr, BASE);
        chk("i_decode", decode(IMM_I, bus.out_instr), 32'hFFFF_F800);
        pop_one();
        chk("i_drained", bus.out_valid, 1'b0);
        chk("i_addr_next", bus.out_addr, BASE + 32'd4);

        // B-format range and alignment
        push(IMM_B, 32'h0000_1000, 32'h0000_0063);
        chk("b_range_err", bus.out_err, 1'b1);
        chk("b_range_cnt", bus.err_count, 8'd1);
        chk("b_range_sticky", bus.err_sticky, 1'b1);
        pop_one();
        push(IMM_B, 32'h0000_0FFE, 32'h0000_0063);
        chk("b_max_err", bus.out_err, 1'b0);
        chk("b_max_instr", bus.out_instr, 32'h7E00_0FE3);
        chk("b_max_decode", decode(IMM_B, bus.out_instr), 32'h0000_0FFE);
        pop_one();
        push(IMM_B, 32'h0000_0003, 32'h0000_0063);
        chk("b_align_err", bus.out_err, 1'b1);
        chk("b_align_cnt", bus.err_count, 8'd2);
        pop_one();
        chk("b_addr", bus.out_addr, BASE + 32'd16);

        // Backpressure: three requests against a stalled consumer
        bus.in_valid   = 1'b1;
        bus.in_imm_src = IMM_I;
        bus.in_base    = 32'h0000_0013;
        bus.in_imm     = 32'd1;
        step();
        chk("bp_ready1", bus.in_ready, 1'b1);
        bus.in_imm     = 32'd2;
        step();
        chk("bp_ready2", bus.in_ready, 1'b0);
        bus.in_imm     = 32'd3;
        step();
        chk("bp_ready3", bus.in_ready, 1'b0);
        chk("bp_hold_instr", bus.out_instr, 32'h0010_0013);
        chk("bp_hold_addr", bus.out_addr, BASE + 32'd16);
        step();
        chk("bp_stable_instr", bus.out_instr, 32'h0010_0013);
        chk("bp_stable_err", bus.out_err, 1'b0);
        bus.out_ready  = 1'b1;
        step();
        chk("bp_w2_instr", bus.out_instr, 32'h0020_0013);
        chk("bp_w2_addr", bus.out_addr, BASE + 32'd20);
        step();
        bus.in_valid   = 1'b0;
        chk("bp_w3_instr", bus.out_instr, 32'h0030_0013);
        chk("bp_w3_addr", bus.out_addr, BASE + 32'd24);
        chk("bp_w3_valid", bus.out_valid, 1'b1);
        step();
        chk("bp_empty", bus.out_valid, 1'b0);
        chk("bp_addr_end", bus.out_addr, BASE + 32'd28);

        // Full-rate J stream
        bus.in_valid   = 1'b1;
        bus.in_imm_src = IMM_J;
        bus.in_base    = 32'h0000_00EF;
        for (int k = 0; k < 16; k++) begin
            bus.in_imm = jimm[k];
            step();
            chk("j_valid", bus.out_valid, 1'b1);
            chk("j_addr", bus.out_addr, BASE + 32'd28 + 32'(4 * k));
            chk("j_decode", decode(IMM_J, bus.out_instr), jimm[k]);
            chk("j_base", {20'h0, bus.out_instr[11:0]}, 32'h0000_00EF);
            if (k == 0) chk("j_word0", bus.out_instr, 32'h7FFF_F0EF);
        end
        bus.in_valid   = 1'b0;
        step();
        bus.out_ready  = 1'b0;
        chk("j_empty", bus.out_valid, 1'b0);
        chk("j_addr_end", bus.out_addr, BASE + 32'd92);

        // Invalid format code
        push(3'b111, 32'h0000_1234, 32'hDEAD_BEEF);
        chk("inv_instr", bus.out_instr, 32'hDEAD_BEEF);
        chk("inv_err", bus.out_err, 1'b1);
        chk("inv_sticky", bus.err_sticky, 1'b1);
        chk("inv_cnt", bus.err_count, 8'd3);
        pop_one();

        // Error counter saturation
        bus.out_ready  = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_imm_src = 3'b111;
        repeat (300) step();
        bus.in_valid   = 1'b0;
        step();
        bus.out_ready  = 1'b0;
        chk("sat_cnt", bus.err_count, 8'd255);

        // Clear together with an erroneous accept
        bus.in_imm_src = IMM_B;
        bus.in_imm     = 32'h0000_0003;
        bus.in_valid   = 1'b1;
        clr            = 1'b1;
        step();
        clr            = 1'b0;
        bus.in_valid   = 1'b0;
        chk("clr_cnt", bus.err_count, 8'd0);
        chk("clr_sticky", bus.err_sticky, 1'b0);
        chk("clr_addr", bus.out_addr, BASE);
        chk("clr_word_kept", bus.out_err, 1'b1);
        pop_one();
        chk("clr_addr_next", bus.out_addr, BASE + 32'd4);

        // Reset with two words queued
        push(IMM_I, 32'd5, 32'h0000_0013);
        push(IMM_I, 32'd6, 32'h0000_0013);
        chk("rq_valid", bus.out_valid, 1'b1);
        chk("rq_ready", bus.in_ready, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rq_out_valid", bus.out_valid, 1'b0);
        chk("rq_addr", bus.out_addr, BASE);
        chk("rq_in_ready", bus.in_ready, 1'b1);
        chk("rq_instr", bus.out_instr, 32'h0);
        step();
        chk("rq_still_empty", bus.out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
